// File: rtl/axi4_lite_burst_master.sv
// AXI4-lite burst master: splits CPU write/read commands into single-beat AXI4-lite transactions.
// Optional AXI4_LITE_ERR_ABORT_EN: the first error response ends the command (write abort flushes the FIFO).
module axi4_lite_burst_master #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int LEN_WIDTH      = 5,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                        axi4_lite_aclk,
    input  logic                        axi4_lite_areset,
    input  logic                        WRITE,
    input  logic                        READ,
    input  logic [ADDRESS_WIDTH-1:0]    CPU_ADDR,
    input  logic [LEN_WIDTH-1:0]        DATA_LENGTH,
    input  logic [REG_DATA_WIDTH-1:0]   DATA_IN,
    input  logic                        DATA_VALID,
    output logic                        DATA_READY,
    output logic [REG_DATA_WIDTH-1:0]   DATA_OUT,
    output logic                        OUT_VALID,
    output logic                        BUSY,
    output logic                        DONE,
    output logic [LEN_WIDTH-1:0]        error_count,
    output logic [ADDRESS_WIDTH-1:0]    awaddr,
    output logic [2:0]                  awprot,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [REG_DATA_WIDTH-1:0]   wdata,
    output logic [REG_DATA_WIDTH/8-1:0] wstrb,
    output logic                        wvalid,
    input  logic                        wready,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready,
    output logic [ADDRESS_WIDTH-1:0]    araddr,
    output logic [2:0]                  arprot,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [REG_DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rvalid,
    output logic                        rready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_INC = ADDRESS_WIDTH'(REG_DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_WAIT, ST_WR_XFER, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA, ST_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
    logic [LEN_WIDTH-1:0]        beats_q, beats_d;
    logic [LEN_WIDTH-1:0]        err_q, err_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic [REG_DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                        oval_q, oval_d;
    logic [PTR_W-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]              cnt_q, cnt_d;
    logic [REG_DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
`ifdef AXI4_LITE_ERR_ABORT_EN
    logic                        abort_q, abort_d;
`endif

    logic push, pop, flush, beat_done, resp_err, fifo_empty;
    logic unused_resp;

    assign unused_resp = bresp[0] ^ rresp[0];
    assign fifo_empty  = (cnt_q == '0);
    assign DATA_READY  = (cnt_q != (PTR_W+1)'(FIFO_DEPTH));
    assign push        = DATA_VALID & DATA_READY & ~flush;

    assign awaddr      = addr_q;
    assign araddr      = addr_q;
    assign awprot      = 3'b000;
    assign arprot      = 3'b000;
    assign wdata       = mem_q[rptr_q];
    assign wstrb       = '1;
    assign awvalid     = (state_q == ST_WR_XFER) & ~aw_done_q;
    assign wvalid      = (state_q == ST_WR_XFER) & ~w_done_q;
    assign bready      = (state_q == ST_WR_RESP);
    assign arvalid     = (state_q == ST_RD_ADDR);
    assign rready      = (state_q == ST_RD_DATA);
    assign BUSY        = (state_q != ST_IDLE) & (state_q != ST_DONE);
    assign DONE        = (state_q == ST_DONE);
    assign error_count = err_q;
    assign DATA_OUT    = dout_q;
    assign OUT_VALID   = oval_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beats_d   = beats_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        pop       = 1'b0;
        flush     = 1'b0;
        beat_done = 1'b0;
        resp_err  = 1'b0;
`ifdef AXI4_LITE_ERR_ABORT_EN
        abort_d   = abort_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if ((WRITE || READ) && DATA_LENGTH != '0) begin
                    state_d = WRITE ? ST_WR_WAIT : ST_RD_ADDR;
                    addr_d  = CPU_ADDR;
                    beats_d = DATA_LENGTH;
                    err_d   = '0;
                end
            end
            ST_WR_WAIT: if (!fifo_empty) state_d = ST_WR_XFER;
            ST_WR_XFER: begin
                // AW and W may handshake in either order; the beat moves on once both have.
                aw_done_d = aw_done_q | (awvalid & awready);
                w_done_d  = w_done_q | (wvalid & wready);
                if (aw_done_d && w_done_d) begin
                    pop       = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: if (bvalid) begin beat_done = 1'b1; resp_err = bresp[1]; end
            ST_RD_ADDR: if (arready) state_d = ST_RD_DATA;
            ST_RD_DATA: if (rvalid) begin beat_done = 1'b1; resp_err = rresp[1]; end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef AXI4_LITE_ERR_ABORT_EN
                flush   = abort_q;
                abort_d = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (beat_done) begin
            beats_d = beats_q - 1'b1;
            addr_d  = addr_q + ADDR_INC;
            if (resp_err && err_q != '1) err_d = err_q + 1'b1;
            if (beats_q == LEN_WIDTH'(1))      state_d = ST_DONE;
            else if (state_q == ST_WR_RESP)    state_d = ST_WR_WAIT;
            else                               state_d = ST_RD_ADDR;
`ifdef AXI4_LITE_ERR_ABORT_EN
            if (resp_err) begin
                state_d = ST_DONE;
                abort_d = (state_q == ST_WR_RESP);
            end
`endif
        end

        oval_d = (state_q == ST_RD_DATA) & rvalid;
        dout_d = oval_d ? rdata : dout_q;

        wptr_d = wptr_q + PTR_W'(push);
        rptr_d = rptr_q + PTR_W'(pop);
        cnt_d  = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        if (flush) begin
            rptr_d = wptr_q;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge axi4_lite_aclk) begin
        if (axi4_lite_areset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            beats_q   <= '0;
            err_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            dout_q    <= '0;
            oval_q    <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
`ifdef AXI4_LITE_ERR_ABORT_EN
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            beats_q   <= beats_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            dout_q    <= dout_d;
            oval_q    <= oval_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
`ifdef AXI4_LITE_ERR_ABORT_EN
            abort_q   <= abort_d;
`endif
        end
    end

    // Storage only; pointer reset is what empties the FIFO.
    always_ff @(posedge axi4_lite_aclk) begin
        if (push) mem_q[wptr_q] <= DATA_IN;
    end
endmodule

// File: doc/axi4_lite_burst_master.md
# axi4_lite_burst_master

Parametrised AXI4-lite master with a CPU-side command port, the successor of the single-beat master used in the top-level AXI4-lite test system. It accepts a write or read command of up to 2^LEN_WIDTH−1 beats, splits it into sequential single AXI4-lite transactions at incrementing addresses, and buffers write data in an internal FIFO. Per-command slave error responses are counted. It sits between the CPU stub and the AXI4-lite slave, on flat AXI4-lite ports.

## Interface
- ADDRESS_WIDTH, 32, AXI/CPU address width
- REG_DATA_WIDTH, 32, data width; multiple of 8
- LEN_WIDTH, 5, beat-count width
- FIFO_DEPTH, 8, write-data FIFO entries; power of two, ≥2

- axi4_lite_aclk  in  1  the only clock
- axi4_lite_areset  in  1  synchronous, active-high reset
- WRITE, READ  in  1  command strobes, sampled only in IDLE
- CPU_ADDR  in  ADDRESS_WIDTH  start address
- DATA_LENGTH  in  LEN_WIDTH  beat count
- DATA_IN  in  REG_DATA_WIDTH; DATA_VALID  in  1; DATA_READY  out  1  write-data push port
- DATA_OUT  out  REG_DATA_WIDTH; OUT_VALID  out  1  read-data output
- BUSY  out  1; DONE  out  1  one-cycle completion pulse
- error_count  out  LEN_WIDTH  error responses in the current/last command
- awaddr/araddr  out  ADDRESS_WIDTH; awprot/arprot  out  3 (tied 3'b000); awvalid, arvalid, wvalid, bready, rready  out  1
- awready, arready, wready, bvalid, rvalid  in  1; wdata  out  REG_DATA_WIDTH; wstrb  out  REG_DATA_WIDTH/8 (all ones); rdata  in  REG_DATA_WIDTH; bresp, rresp  in  2

## Operation
- FSM states: IDLE, WR_WAIT, WR_XFER, WR_RESP, RD_ADDR, RD_DATA, DONE.
- Commands are accepted only in IDLE.
  - IDLE with WRITE=1 and DATA_LENGTH≠0 → WR_WAIT. WRITE wins if READ is also high.
  - READ=1 and DATA_LENGTH≠0 → RD_ADDR.
  - Length 0 is ignored (no DONE pulse).
  - On accept, CPU_ADDR and DATA_LENGTH are latched and error_count is cleared.
- Write path:
  - WR_WAIT → WR_XFER when the FIFO is non-empty.
  - WR_XFER asserts awvalid and wvalid together, with wdata = FIFO head. Each valid is held until its own handshake; AW and W may complete in either order or together.
  - Once both handshakes are done, the FIFO is popped and the FSM enters WR_RESP, where bready=1.
- Read path: RD_ADDR asserts arvalid until arready, then RD_DATA with rready=1.
- Beat completion: on the bvalid or rvalid handshake, the beat counter decrements and the address advances by REG_DATA_WIDTH/8, wrapping modulo 2^ADDRESS_WIDTH.
  - Write: last beat → DONE, otherwise WR_WAIT.
  - Read: last beat → DONE, otherwise RD_ADDR.
- Error counting: resp[1]=1 (SLVERR/DECERR) increments error_count, saturating at 2^LEN_WIDTH−1.
- Read data: DATA_OUT ← rdata registered on each R handshake; OUT_VALID is high for exactly that following cycle, regardless of rresp.
- DONE: high for one cycle, then IDLE. BUSY = (state ≠ IDLE) and is low in the DONE cycle.
- FIFO:
  - A push occurs when DATA_VALID & DATA_READY, in any state. DATA_READY = !full.
  - A push and a pop in the same cycle are both honoured.
  - The FIFO is not flushed at command end; leftover words feed the next write.

## Timing
- Reset clears all state: all outputs 0, FIFO empty, DATA_READY=1. Reset mid-burst abandons the burst immediately and drops all valids in the next cycle.
- Command accepted at edge N; awvalid/wvalid rise at N+2 if the FIFO was non-empty (WR_WAIT occupies one cycle).
- arvalid rises at N+1 after the command edge.
- Zero-wait slave gives the following per-beat costs:
  - Write: 3 cycles (WR_WAIT, WR_XFER, WR_RESP).
  - Read: 2 cycles (RD_ADDR, RD_DATA).
- DONE is asserted the cycle after the last B/R handshake; the next command can be accepted the cycle after DONE.
- OUT_VALID is asserted 1 cycle after the R handshake.

## Configuration
- AXI4_LITE_ERR_ABORT_EN defined: the first error response ends the command.
  - Remaining beats are skipped and the FSM goes to DONE.
  - On a write abort, the FIFO is flushed in the DONE cycle; pushes in that cycle are dropped.
  - error_count is 1 after an abort.
- Undefined: every beat is issued regardless of responses, and errors are only counted.

## Test plan
- Write, len 4, addr 0x100; FIFO preloaded 0xA..0xD; zero-wait slave → awaddr 0x100, 0x104, 0x108, 0x10C carrying 0xA–0xD; one DONE; error_count 0.
- Read, len 3, addr 0xFFFF_FFFC → araddr 0xFFFF_FFFC, 0x0, 0x4; three OUT_VALID pulses with the returned rdata; addresses wrap.
- Write with awready delayed 3 cycles and wready immediate → wvalid drops after its handshake, awvalid is held, and a single pop occurs per beat.
- Read, len 4; slave returns SLVERR on beat 2:
  - Macro off: 4 beats issued, error_count=1.
  - Macro on: 2 beats issued, DONE, error_count=1.
- Push 9 words into an 8-deep FIFO while idle → DATA_READY low after the 8th push, 9th word rejected; a write with len 8 drains it.
- Reset asserted mid-write burst → all valids, BUSY, DONE and error_count are 0 the next cycle and the FIFO is empty; a new READ is accepted afterward.
